// File: rtl/medidor_periodo_if.sv
// -----------------------------------------------------------------------------
// medidor_periodo_if
// Bundle carrying the control input, the signal under measurement and the
// measurement results of medidor_periodo_m.
//   Enable     : level, meter runs while high
//   Sig_in     : asynchronous signal whose period/high time is measured
//   Period_out : Clk_in cycles between the last two rising edges
//   High_out   : Clk_in cycles Sig_in was high within that period
//   Valid      : one-cycle strobe marking new Period_out/High_out
//   Timeout    : sticky flag, no rising edge seen within TIMEOUT cycles
// Modports: master drives Enable/Sig_in, slave (the meter) drives results.
// -----------------------------------------------------------------------------
interface medidor_periodo_if #(
    parameter int unsigned WIDTH = 33
);
    logic             Enable;
    logic             Sig_in;
    logic [WIDTH-1:0] Period_out;
    logic [WIDTH-1:0] High_out;
    logic             Valid;
    logic             Timeout;

    modport master (
        output Enable,
        output Sig_in,
        input  Period_out,
        input  High_out,
        input  Valid,
        input  Timeout
    );

    modport slave (
        input  Enable,
        input  Sig_in,
        output Period_out,
        output High_out,
        output Valid,
        output Timeout
    );
endinterface

// File: rtl/medidor_periodo_m.sv
// -----------------------------------------------------------------------------
// medidor_periodo_m
// Period and duty meter for slow clock-like signals. Sig_in is synchronized
// into the Clk_in domain; the meter counts Clk_in cycles between consecutive
// rising edges (period) and from rise to fall (high time), and publishes each
// completed measurement with a one-cycle Valid strobe.
// Ports:
//   Clk_in : system clock, all logic on its rising edge
//   Rst    : synchronous active-high reset
//   bus    : medidor_periodo_if.slave (Enable, Sig_in in; Period_out,
//            High_out, Valid, Timeout out; all outputs registered)
// Parameters:
//   WIDTH   : counter and result width
//   TIMEOUT : cycles without a rising edge before the measurement is dropped;
//             must be below 2^WIDTH-1 so the counter never wraps
// -----------------------------------------------------------------------------
module medidor_periodo_m #(
    parameter int unsigned      WIDTH   = 33,
    parameter logic [WIDTH-1:0] TIMEOUT = 33'd100_000_000
) (
    input  logic               Clk_in,
    input  logic               Rst,
    medidor_periodo_if.slave   bus
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_MEASURE   = 2'd3
    } state_t;

    // Synchronizer (s1_r, s2_r) and edge-history flop (s3_r)
    logic s1_r;
    logic s2_r;
    logic s3_r;
    logic rise_s;
    logic fall_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_nxt_s;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] high_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             timeout_r;
    logic             timeout_nxt_s;

    // Input synchronizer and edge history; runs regardless of FSM state
    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.Sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~s3_r;
    assign fall_s = ~s2_r & s3_r;

    // FSM state and measurement datapath registers
    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            hi_r      <= CNT_ZERO;
            period_r  <= CNT_ZERO;
            high_r    <= CNT_ZERO;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            hi_r      <= hi_nxt_s;
            period_r  <= period_nxt_s;
            high_r    <= high_nxt_s;
            valid_r   <= valid_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    // Next-state and datapath decode; Enable=0 overrides rise, rise overrides timeout
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        hi_nxt_s      = hi_r;
        period_nxt_s  = period_r;
        high_nxt_s    = high_r;
        valid_nxt_s   = 1'b0;
        timeout_nxt_s = timeout_r;

        if (!bus.Enable) begin
            // Held idle: results and the sticky flag keep their values
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    // A high level here would otherwise produce a bogus first edge
                    if (!s2_r) begin
                        state_nxt_s = ST_WAIT_RISE;
                    end else begin
                        state_nxt_s = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise_s) begin
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ST_MEASURE;
                    end else begin
                        state_nxt_s = ST_WAIT_RISE;
                    end
                end
                ST_MEASURE: begin
                    if (fall_s) begin
                        hi_nxt_s = cnt_r;
                    end else begin
                        hi_nxt_s = hi_r;
                    end

                    if (rise_s) begin
                        // Close this period and immediately start the next one
                        period_nxt_s  = cnt_r;
                        high_nxt_s    = hi_r;
                        valid_nxt_s   = 1'b1;
                        timeout_nxt_s = 1'b0;
                        cnt_nxt_s     = CNT_ONE;
                        state_nxt_s   = ST_MEASURE;
                    end else if (cnt_r == TIMEOUT) begin
                        timeout_nxt_s = 1'b1;
                        state_nxt_s   = ST_WAIT_LOW;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = ST_MEASURE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Period_out = period_r;
    assign bus.High_out   = high_r;
    assign bus.Valid      = valid_r;
    assign bus.Timeout    = timeout_r;

endmodule
